// File: rtl/mux_scan_pkg.sv
// Shared constants for the channel-scan sequencer in front of the 8:1 mux.
package mux_scan_pkg;

    localparam int NUM_CH                = 8;
    localparam int SEL_W                 = 3;
    localparam int DEFAULT_SETTLE_CYCLES = 2;

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    // Scan controller states, kept as plain constants so older tools can read them
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_SAMPLE = 2'd2;
    localparam state_t ST_HOLD   = 2'd3;

endpackage

// File: rtl/mux_settle_timer.sv
// Down-counter that measures how long the mux select has been held.
// Loading sets the count to LOAD_VAL; done is high once the count reaches zero,
// which marks the last settle cycle of a channel.
module mux_settle_timer #(
    parameter int CNT_W    = 4,
    parameter int LOAD_VAL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic done
);

    logic [CNT_W-1:0] count;

    // Reload on channel entry, otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(LOAD_VAL);
        end else if (enable && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks the 8:1 mux select through channels 0..7, waits a settle time on each,
// samples the mux output, and hands the assembled 8-bit frame downstream on a
// valid/ready handshake. Continuous mode restarts the scan right after each handshake.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    output logic [2:0] sel,
    input  logic       mux_y,
    output logic [7:0] frame_data,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy
);

    state_t           state;
    logic [SEL_W-1:0] ch;
    logic [NUM_CH-1:0] frame_reg;
    logic             handshake;
    logic             timer_load;
    logic             timer_done;

    assign handshake = (state == ST_HOLD) && frame_ready;

    // Restart the settle timer on every edge that enters SETTLE
    always_comb begin
        timer_load = 1'b0;
        if ((state == ST_IDLE) && start) begin
            timer_load = 1'b1;
        end else if ((state == ST_SAMPLE) && (ch != LAST_CH)) begin
            timer_load = 1'b1;
        end else if (handshake && cont) begin
            timer_load = 1'b1;
        end
    end

    mux_settle_timer #(
        .CNT_W   (CNT_W),
        .LOAD_VAL(SETTLE_CYCLES - 1)
    ) u_settle_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (timer_load),
        .enable(state == ST_SETTLE),
        .done  (timer_done)
    );

    // Scan FSM together with the channel index and the frame capture register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ch        <= '0;
            frame_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_SETTLE;
                        ch        <= '0;
                        frame_reg <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (timer_done) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    frame_reg[ch] <= mux_y;
                    if (ch == LAST_CH) begin
                        state <= ST_HOLD;
                    end else begin
                        state <= ST_SETTLE;
                        ch    <= ch + SEL_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (frame_ready) begin
                        ch <= '0;
                        if (cont) begin
                            state     <= ST_SETTLE;
                            frame_reg <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ch    <= '0;
                end
            endcase
        end
    end

    assign sel         = ch;
    assign frame_data  = frame_reg;
    assign frame_valid = (state == ST_HOLD);
    assign busy        = (state != ST_IDLE);

endmodule
